// File: rtl/fdtd_ctrl_pkg.sv
// Shared constants for the FDTD step sequencer: APB register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package fdtd_ctrl_pkg;

    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_STATUS  = 5'h04;
    localparam logic [4:0] OFF_NSTEPS  = 5'h08;
    localparam logic [4:0] OFF_STEPCNT = 5'h0C;
    localparam logic [4:0] OFF_BASE    = 5'h10;
    localparam logic [4:0] OFF_TMO     = 5'h14;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ABORTED = 2;
    localparam int ST_TIMEOUT = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/fdtd_ctrl_regs.sv
// APB register file for the FDTD step sequencer: decode, RW config, sticky
// W1C status and W1 command strobes. FDTD_STEP_TIMEOUT_EN adds the TMO register.
module fdtd_ctrl_regs
    import fdtd_ctrl_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int STEP_W         = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [31:0]               pwdata,
    input  logic                      pwrite,
    input  logic                      psel,
    input  logic                      penable,
    output logic [31:0]               prdata,
    output logic                      pslverr,
    input  logic                      busy,
    input  logic [STEP_W-1:0]         stepcnt,
    input  logic                      set_done,
    input  logic                      set_aborted,
`ifdef FDTD_STEP_TIMEOUT_EN
    input  logic                      set_timeout,
    output logic [31:0]               tmo,
`endif
    input  logic                      clr_flags,
    output logic                      start_req,
    output logic                      abort_req,
    output logic [STEP_W-1:0]         nsteps,
    output logic [31:0]               grid_base,
    output logic                      irq
);

    logic [4:0]        offset;
    logic              unused_paddr_hi;
    logic              access;
    logic              mapped;
    logic              cfg_reg;
    logic              err;
    logic              wr_ok;
    logic [31:0]       rdata;
    logic              irq_en_q;
    logic              done_q;
    logic              aborted_q;
    logic              timeout_q;
    logic [STEP_W-1:0] nsteps_q;
    logic [31:0]       base_q;
    logic              w1c_wr;

    assign offset          = paddr[4:0];
    assign unused_paddr_hi = ^paddr[APB_ADDR_WIDTH-1:5];
    assign access          = psel & penable;

    always_comb begin
        mapped  = 1'b1;
        cfg_reg = 1'b0;
        rdata   = '0;
        case (offset)
            OFF_CTRL:    rdata[CTRL_IRQ_EN] = irq_en_q;
            OFF_STATUS: begin
                rdata[ST_BUSY]    = busy;
                rdata[ST_DONE]    = done_q;
                rdata[ST_ABORTED] = aborted_q;
                rdata[ST_TIMEOUT] = timeout_q;
            end
            OFF_NSTEPS: begin
                rdata   = 32'(nsteps_q);
                cfg_reg = 1'b1;
            end
            OFF_STEPCNT: rdata = 32'(stepcnt);
            OFF_BASE: begin
                rdata   = base_q;
                cfg_reg = 1'b1;
            end
`ifdef FDTD_STEP_TIMEOUT_EN
            OFF_TMO: begin
                rdata   = tmo;
                cfg_reg = 1'b1;
            end
`endif
            default: mapped = 1'b0;
        endcase
    end

    // Config registers are frozen while a run is in progress.
    assign err     = ~mapped | (pwrite & cfg_reg & busy);
    assign pslverr = access & err;
    assign prdata  = (access & mapped) ? rdata : 32'd0;
    assign wr_ok   = access & pwrite & ~err;

    // ABORT takes priority over START in a combined write.
    assign start_req = wr_ok && (offset == OFF_CTRL) && pwdata[CTRL_START] && !pwdata[CTRL_ABORT];
    assign abort_req = wr_ok && (offset == OFF_CTRL) && pwdata[CTRL_ABORT];
    assign w1c_wr    = wr_ok && (offset == OFF_STATUS);

    assign nsteps    = nsteps_q;
    assign grid_base = base_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q  <= 1'b0;
            nsteps_q  <= '0;
            base_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_ok && offset == OFF_CTRL)   irq_en_q <= pwdata[CTRL_IRQ_EN];
            if (wr_ok && offset == OFF_NSTEPS) nsteps_q <= pwdata[STEP_W-1:0];
            if (wr_ok && offset == OFF_BASE)   base_q   <= pwdata;
            // A hardware set in the same cycle as a W1C keeps the flag.
            done_q    <= set_done    | (done_q    & ~clr_flags & ~(w1c_wr & pwdata[ST_DONE]));
            aborted_q <= set_aborted | (aborted_q & ~clr_flags & ~(w1c_wr & pwdata[ST_ABORTED]));
            irq       <= irq_en_q & (done_q | timeout_q);
        end
    end

`ifdef FDTD_STEP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo       <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (wr_ok && offset == OFF_TMO) tmo <= pwdata;
            timeout_q <= set_timeout | (timeout_q & ~clr_flags & ~(w1c_wr & pwdata[ST_TIMEOUT]));
        end
    end
`else
    assign timeout_q = 1'b0;
`endif

endmodule

// File: rtl/fdtd_step_ctrl.sv
// FDTD time-step sequencer: launches one engine step at a time, counts completed
// steps, handles abort and raises the interrupt. FDTD_STEP_TIMEOUT_EN adds a WAIT watchdog.
module fdtd_step_ctrl
    import fdtd_ctrl_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int STEP_W         = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      step_start_o,
    input  logic                      step_done_i,
    output logic [STEP_W-1:0]         step_idx_o,
    output logic [31:0]               grid_base_o,
    output logic                      int_o
);

    state_t            state_q;
    state_t            state_d;
    logic [STEP_W-1:0] stepcnt_q;
    logic [STEP_W-1:0] stepcnt_inc;
    logic [STEP_W-1:0] nsteps;
    logic              abort_pend_q;
    logic              busy;
    logic              start_req;
    logic              abort_req;
    logic              set_done;
    logic              set_aborted;
    logic              clr_flags;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              timeout_hit;
`ifdef FDTD_STEP_TIMEOUT_EN
    logic [31:0]       tmo;
    logic [31:0]       wd_q;
    logic              set_timeout;
`endif

    fdtd_ctrl_regs #(
        .APB_ADDR_WIDTH(APB_ADDR_WIDTH),
        .STEP_W        (STEP_W)
    ) u_regs (
        .clk        (clk_i),
        .rst_n      (rst_n),
        .paddr      (PADDR),
        .pwdata     (PWDATA),
        .pwrite     (PWRITE),
        .psel       (PSEL),
        .penable    (PENABLE),
        .prdata     (PRDATA),
        .pslverr    (PSLVERR),
        .busy       (busy),
        .stepcnt    (stepcnt_q),
        .set_done   (set_done),
        .set_aborted(set_aborted),
`ifdef FDTD_STEP_TIMEOUT_EN
        .set_timeout(set_timeout),
        .tmo        (tmo),
`endif
        .clr_flags  (clr_flags),
        .start_req  (start_req),
        .abort_req  (abort_req),
        .nsteps     (nsteps),
        .grid_base  (grid_base_o),
        .irq        (int_o)
    );

    assign PREADY       = 1'b1;
    assign busy         = (state_q != S_IDLE);
    assign step_start_o = (state_q == S_LAUNCH);
    assign step_idx_o   = stepcnt_q;
    assign stepcnt_inc  = stepcnt_q + STEP_W'(1);

`ifdef FDTD_STEP_TIMEOUT_EN
    // wd_q holds the WAIT cycles already elapsed, so this fires in the TMO-th one.
    assign timeout_hit = (tmo != 32'd0) && (wd_q == tmo - 32'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        set_done    = 1'b0;
        set_aborted = 1'b0;
        clr_flags   = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
`ifdef FDTD_STEP_TIMEOUT_EN
        set_timeout = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    // STEPCNT restarts even for an empty run so it reflects this run.
                    cnt_clr = 1'b1;
                    if (nsteps == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        clr_flags = 1'b1;
                        state_d   = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (step_done_i) begin
                    cnt_inc = 1'b1;
                    if (abort_pend_q) begin
                        set_aborted = 1'b1;
                        state_d     = S_FINISH;
                    end else if (stepcnt_inc == nsteps) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end else if (timeout_hit) begin
                    set_aborted = 1'b1;
`ifdef FDTD_STEP_TIMEOUT_EN
                    set_timeout = 1'b1;
`endif
                    state_d     = S_FINISH;
                end
            end
            S_FINISH: begin
                set_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            stepcnt_q    <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cnt_clr)      stepcnt_q <= '0;
            else if (cnt_inc) stepcnt_q <= stepcnt_inc;
            if (state_q == S_FINISH)   abort_pend_q <= 1'b0;
            else if (abort_req && busy) abort_pend_q <= 1'b1;
        end
    end

`ifdef FDTD_STEP_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                 wd_q <= '0;
        else if (state_q == S_LAUNCH) wd_q <= '0;
        else if (state_q == S_WAIT)   wd_q <= wd_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fdtd_step_ctrl.sv
// Directed bench for fdtd_step_ctrl with a behavioural FDTD engine that answers
// each start pulse with a done pulse five cycles later.
module tb_fdtd_step_ctrl;

    localparam logic [11:0] A_CTRL    = 12'h000;
    localparam logic [11:0] A_STATUS  = 12'h004;
    localparam logic [11:0] A_NSTEPS  = 12'h008;
    localparam logic [11:0] A_STEPCNT = 12'h00C;
    localparam logic [11:0] A_BASE    = 12'h010;
    localparam logic [11:0] A_TMO     = 12'h014;
    localparam logic [11:0] A_BAD     = 12'h01C;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        step_start_o;
    logic        step_done_i;
    logic [15:0] step_idx_o;
    logic [31:0] grid_base_o;
    logic        int_o;

    logic        eng_en = 1'b0;
    logic        eng_done = 1'b0;
    logic        man_done = 1'b0;
    int          cd = 0;
    int          pulses = 0;
    logic [15:0] idx_log [16];

    int checks = 0;
    int errors = 0;

    assign step_done_i = eng_done | man_done;

    fdtd_step_ctrl dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .step_start_o(step_start_o),
        .step_done_i (step_done_i),
        .step_idx_o  (step_idx_o),
        .grid_base_o (grid_base_o),
        .int_o       (int_o)
    );

    always #5 clk_i = ~clk_i;

    // Engine model: logs every start pulse and answers 5 cycles later when enabled.
    always @(negedge clk_i) begin
        eng_done = 1'b0;
        if (cd != 0) begin
            cd = cd - 1;
            if (cd == 0) eng_done = 1'b1;
        end
        if (step_start_o) begin
            if (pulses < 16) idx_log[pulses] = step_idx_o;
            pulses = pulses + 1;
            if (eng_en) cd = 5;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        @(negedge clk_i);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge clk_i);
        PENABLE = 1'b1;
        #4;
        err = PSLVERR;
        @(negedge clk_i);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(negedge clk_i);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge clk_i);
        PENABLE = 1'b1;
        #4;
        d   = PRDATA;
        err = PSLVERR;
        @(negedge clk_i);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        // Reset values
        #1;
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        check("rst_pslverr", 32'(PSLVERR), 32'h0);
        check("rst_start", 32'(step_start_o), 32'h0);
        check("rst_idx", 32'(step_idx_o), 32'h0);
        check("rst_base", grid_base_o, 32'h0);
        check("rst_int", 32'(int_o), 32'h0);
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        apb_read(A_STATUS, rd, err);
        check("rst_status", rd, 32'h0);

        // Three-step run with interrupt enabled
        eng_en = 1'b1;
        apb_write(A_NSTEPS, 32'd3, err);
        check("nsteps_wr_err", 32'(err), 32'h0);
        apb_write(A_BASE, 32'h1000_0000, err);
        apb_write(A_CTRL, 32'h4, err);
        apb_write(A_CTRL, 32'h5, err);
        apb_read(A_STATUS, rd, err);
        check("run3_busy", rd, 32'h1);
        repeat (30) @(negedge clk_i);
        check("run3_pulses", pulses, 3);
        check("run3_idx0", 32'(idx_log[0]), 32'h0);
        check("run3_idx1", 32'(idx_log[1]), 32'h1);
        check("run3_idx2", 32'(idx_log[2]), 32'h2);
        apb_read(A_STEPCNT, rd, err);
        check("run3_stepcnt", rd, 32'd3);
        apb_read(A_STATUS, rd, err);
        check("run3_status", rd, 32'h2);
        check("run3_int", 32'(int_o), 32'h1);
        check("run3_base", grid_base_o, 32'h1000_0000);

        // W1C of DONE drops the interrupt
        apb_write(A_STATUS, 32'h2, err);
        @(negedge clk_i);
        apb_read(A_STATUS, rd, err);
        check("w1c_status", rd, 32'h0);
        check("w1c_int", 32'(int_o), 32'h0);

        // Empty run: no pulse, DONE within 2 cycles, STEPCNT restarts
        pulses = 0;
        apb_write(A_NSTEPS, 32'd0, err);
        apb_write(A_CTRL, 32'h5, err);
        @(negedge clk_i);
        check("zero_pulses", pulses, 0);
        apb_read(A_STATUS, rd, err);
        check("zero_status", rd, 32'h2);
        apb_read(A_STEPCNT, rd, err);
        check("zero_stepcnt", rd, 32'h0);

        // Ten-step run, config write while busy, abort during step 4
        pulses = 0;
        apb_write(A_NSTEPS, 32'd10, err);
        apb_write(A_CTRL, 32'h5, err);
        apb_write(A_NSTEPS, 32'd7, err);
        check("busy_wr_err", 32'(err), 32'h1);
        apb_read(A_NSTEPS, rd, err);
        check("busy_nsteps", rd, 32'd10);
        check("busy_rd_err", 32'(err), 32'h0);
        apb_read(A_BAD, rd, err);
        check("bad_err", 32'(err), 32'h1);
        check("bad_data", rd, 32'h0);
        for (int i = 0; i < 200 && pulses < 5; i++) begin
            @(negedge clk_i);
            #1;
        end
        check("abort_wait", pulses, 5);
        apb_write(A_CTRL, 32'h6, err);
        repeat (15) @(negedge clk_i);
        check("abort_pulses", pulses, 5);
        apb_read(A_STEPCNT, rd, err);
        check("abort_stepcnt", rd, 32'd5);
        apb_read(A_STATUS, rd, err);
        check("abort_status", rd, 32'h6);

        // START and ABORT together while idle: nothing happens
        apb_write(A_CTRL, 32'h7, err);
        repeat (5) @(negedge clk_i);
        check("sa_pulses", pulses, 5);
        apb_read(A_STATUS, rd, err);
        check("sa_status", rd, 32'h6);

`ifdef FDTD_STEP_TIMEOUT_EN
        // Watchdog: engine silent, TMO=20
        eng_en = 1'b0;
        pulses = 0;
        apb_write(A_TMO, 32'd20, err);
        check("tmo_wr_err", 32'(err), 32'h0);
        apb_write(A_NSTEPS, 32'd1, err);
        apb_write(A_CTRL, 32'h5, err);
        check("tmo_pulse", pulses, 1);
        repeat (19) @(negedge clk_i);
        apb_read(A_STATUS, rd, err);
        check("tmo_finish_status", rd, 32'hD);
        apb_read(A_STATUS, rd, err);
        check("tmo_idle_status", rd, 32'hE);
        check("tmo_int", 32'(int_o), 32'h1);
        apb_write(A_STATUS, 32'hE, err);
        @(negedge clk_i);
        apb_read(A_STATUS, rd, err);
        check("tmo_w1c_status", rd, 32'h0);
        check("tmo_w1c_int", 32'(int_o), 32'h0);
        apb_write(A_TMO, 32'd0, err);
        eng_en = 1'b1;
`else
        apb_read(A_TMO, rd, err);
        check("tmo_unmapped_err", 32'(err), 32'h1);
        check("tmo_unmapped_data", rd, 32'h0);
`endif

        // Asynchronous reset in the WAIT of step 2, then a late done
        eng_en = 1'b1;
        pulses = 0;
        apb_write(A_NSTEPS, 32'd5, err);
        apb_write(A_CTRL, 32'h5, err);
        for (int i = 0; i < 200 && pulses < 3; i++) begin
            @(negedge clk_i);
            #1;
        end
        check("rstrun_wait", pulses, 3);
        check("rstrun_idx", 32'(step_idx_o), 32'h2);
        @(negedge clk_i);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_start", 32'(step_start_o), 32'h0);
        check("arst_idx", 32'(step_idx_o), 32'h0);
        check("arst_base", grid_base_o, 32'h0);
        check("arst_int", 32'(int_o), 32'h0);
        check("arst_pready", 32'(PREADY), 32'h1);
        @(negedge clk_i);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_i);
        man_done = 1'b1;
        @(negedge clk_i);
        man_done = 1'b0;
        apb_read(A_STEPCNT, rd, err);
        check("late_done_stepcnt", rd, 32'h0);
        apb_read(A_STATUS, rd, err);
        check("late_done_status", rd, 32'h0);
        check("late_done_pulses", pulses, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
